// File: rtl/bsg_vanilla_pkg.sv
// Shared types and helpers for the vanilla tile remote-load response path.
//   vanilla_rf_chan_e : register-file channel ids used on returned_chan_id_i.
//   load_resp_s       : queue payload {reg_id, data} at the default tile geometry.
//   clog2_min1()      : ceil(log2(n)) but never below 1, for select/pointer widths.
package bsg_vanilla_pkg;

    typedef enum logic [0:0] {
        RF_CHAN_INT   = 1'b0,
        RF_CHAN_FLOAT = 1'b1
    } vanilla_rf_chan_e;

    localparam int load_resp_data_width_gp   = 32;
    localparam int load_resp_reg_id_width_gp = 5;

    typedef struct packed {
        logic [load_resp_reg_id_width_gp-1:0] reg_id;
        logic [load_resp_data_width_gp-1:0]   data;
    } load_resp_s;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vanilla_load_resp_chan.sv
// One register-file channel of the load response router: a circular queue of
// {reg_id, data}, an age counter on the head entry, and the sticky force
// request that asks the core to stall and write the head back.
//   clk_i, reset_n_i : clock, async active-low reset
//   enq_i            : push enq_rd_i/enq_data_i (ignored while full)
//   fifo_full_i      : endpoint returned FIFO is full
//   yumi_i           : core consumes the head this cycle
//   full_o, v_o      : queue full / head valid
//   rd_o, data_o     : head entry, driven straight from storage
//   force_o          : force-writeback request for the head
module vanilla_load_resp_chan
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5,
    parameter int els_p            = 2,
    parameter int force_age_p      = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        enq_i,
    input  logic [reg_addr_width_p-1:0] enq_rd_i,
    input  logic [data_width_p-1:0]     enq_data_i,
    input  logic                        fifo_full_i,
    input  logic                        yumi_i,
    output logic                        full_o,
    output logic                        v_o,
    output logic [reg_addr_width_p-1:0] rd_o,
    output logic [data_width_p-1:0]     data_o,
    output logic                        force_o
);

    localparam int ptr_w_lp = clog2_min1(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int age_w_lp = $clog2(force_age_p + 1);

    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(els_p);
    localparam logic [age_w_lp-1:0] age_max_lp  = age_w_lp'(force_age_p);

    typedef struct packed {
        logic [reg_addr_width_p-1:0] reg_id;
        logic [data_width_p-1:0]     data;
    } entry_s;

    entry_s              mem_r [els_p];
    logic [ptr_w_lp-1:0] rptr_r, wptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic [age_w_lp-1:0] age_r;
    logic                force_r;
    logic                enq, deq;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    assign full_o = (count_r == els_cnt_lp);
    assign v_o    = (count_r != '0);
    // Full blocks the push even when the head leaves the same cycle.
    assign enq    = enq_i & ~full_o;
    assign deq    = yumi_i & v_o;

    assign rd_o   = mem_r[rptr_r].reg_id;
    assign data_o = mem_r[rptr_r].data;

    // Age term comes from a register; fifo-full term is live; force_r keeps
    // the request up for the same head once it has been raised.
    assign force_o = v_o & ((age_r == age_max_lp) | (fifo_full_i & full_o) | force_r);

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= '{reg_id: enq_rd_i, data: enq_data_i};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
            age_r   <= '0;
            force_r <= 1'b0;
        end else begin
            if (enq) wptr_r <= ptr_inc(wptr_r);
            if (deq) rptr_r <= ptr_inc(rptr_r);

            case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: ;
            endcase

            // A new head (dequeue, or first push into empty) starts fresh.
            if (deq | (enq & ~v_o))
                age_r <= '0;
            else if (v_o && age_r != age_max_lp)
                age_r <= age_r + 1'b1;

            if (deq)
                force_r <= 1'b0;
            else if (force_o)
                force_r <= 1'b1;
        end
    end

    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

endmodule

// File: rtl/vanilla_load_resp_router.sv
// Remote-load response router for the vanilla tile. Takes returned load
// packets from the endpoint FIFO and steers each into the queue of its
// register-file channel (int, float, ...). Each channel exposes its head and a
// force request so the core can stall and write back an aged response.
//   clk_i, reset_n_i            : clock, async active-low reset
//   returned_v_i/_data_i/_reg_id_i/_chan_id_i : incoming packet
//   returned_fifo_full_i        : endpoint returned FIFO is full
//   returned_yumi_o             : packet consumed this cycle
//   resp_v_o/_rd_o/_data_o      : per-channel head (packed, channel 0 in LSBs)
//   resp_force_o                : per-channel force-writeback request
//   resp_yumi_i                 : per-channel head consumed by the core
//   err_o                       : sticky, an out-of-range channel id was seen
module vanilla_load_resp_router
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p     = load_resp_data_width_gp,
    parameter int reg_addr_width_p = load_resp_reg_id_width_gp,
    parameter int num_chan_p       = 2,
    parameter int chan_els_p       = 2,
    parameter int force_age_p      = 16,
    localparam int chan_id_width_lp = clog2_min1(num_chan_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   returned_v_i,
    input  logic [data_width_p-1:0]                returned_data_i,
    input  logic [reg_addr_width_p-1:0]            returned_reg_id_i,
    input  logic [chan_id_width_lp-1:0]            returned_chan_id_i,
    input  logic                                   returned_fifo_full_i,
    output logic                                   returned_yumi_o,
    output logic [num_chan_p-1:0]                  resp_v_o,
    output logic [num_chan_p*reg_addr_width_p-1:0] resp_rd_o,
    output logic [num_chan_p*data_width_p-1:0]     resp_data_o,
    output logic [num_chan_p-1:0]                  resp_force_o,
    input  logic [num_chan_p-1:0]                  resp_yumi_i,
    output logic                                   err_o
);

    // Pad per-channel vectors out to every encodable id so the input id can
    // index them directly; ids past num_chan_p read as illegal and full.
    localparam int id_space_lp = 1 << chan_id_width_lp;
    localparam logic [id_space_lp-1:0] legal_mask_lp =
        id_space_lp'((64'd1 << num_chan_p) - 64'd1);

    logic [num_chan_p-1:0]  chan_full;
    logic [id_space_lp-1:0] full_pad;
    logic                   chan_legal;
    logic                   err_r;

    always_comb begin
        full_pad                 = '1;
        full_pad[num_chan_p-1:0] = chan_full;
    end

    assign chan_legal = legal_mask_lp[returned_chan_id_i];

    // Head-of-line: a packet whose channel is full holds up the whole input.
    assign returned_yumi_o = reset_n_i & returned_v_i & chan_legal
                           & ~full_pad[returned_chan_id_i];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            err_r <= 1'b0;
        else if (returned_v_i & ~chan_legal)
            err_r <= 1'b1;
    end

    assign err_o = err_r;

    for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
        logic enq;
        assign enq = returned_yumi_o
                   & (returned_chan_id_i == chan_id_width_lp'(c));

        vanilla_load_resp_chan #(
            .data_width_p     (data_width_p),
            .reg_addr_width_p (reg_addr_width_p),
            .els_p            (chan_els_p),
            .force_age_p      (force_age_p)
        ) u_chan (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .enq_i       (enq),
            .enq_rd_i    (returned_reg_id_i),
            .enq_data_i  (returned_data_i),
            .fifo_full_i (returned_fifo_full_i),
            .yumi_i      (resp_yumi_i[c]),
            .full_o      (chan_full[c]),
            .v_o         (resp_v_o[c]),
            .rd_o        (resp_rd_o[c*reg_addr_width_p +: reg_addr_width_p]),
            .data_o      (resp_data_o[c*data_width_p +: data_width_p]),
            .force_o     (resp_force_o[c])
        );
    end

endmodule

// File: tb/tb_vanilla_load_resp_router.sv
module tb_vanilla_load_resp_router;
    import bsg_vanilla_pkg::*;

    localparam int NCH = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        returned_v;
    logic [31:0] returned_data;
    logic [4:0]  returned_reg_id;
    logic [1:0]  returned_chan_id;
    logic        fifo_full;
    logic        yumi_o;
    logic [2:0]  resp_v;
    logic [14:0] resp_rd;
    logic [95:0] resp_data;
    logic [2:0]  resp_force;
    logic [2:0]  resp_yumi;
    logic        err;

    int nchk = 0;
    int nerr = 0;

    load_resp_s exp_q [NCH][$];
    load_resp_s mon_e;

    always #5 clk = ~clk;

    vanilla_load_resp_router #(
        .data_width_p     (32),
        .reg_addr_width_p (5),
        .num_chan_p       (3),
        .chan_els_p       (3),
        .force_age_p      (4)
    ) dut (
        .clk_i                (clk),
        .reset_n_i            (rst_n),
        .returned_v_i         (returned_v),
        .returned_data_i      (returned_data),
        .returned_reg_id_i    (returned_reg_id),
        .returned_chan_id_i   (returned_chan_id),
        .returned_fifo_full_i (fifo_full),
        .returned_yumi_o      (yumi_o),
        .resp_v_o             (resp_v),
        .resp_rd_o            (resp_rd),
        .resp_data_o          (resp_data),
        .resp_force_o         (resp_force),
        .resp_yumi_i          (resp_yumi),
        .err_o                (err)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every head the bench consumes must match the
    // oldest outstanding packet issued to that channel.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                if (resp_yumi[c]) begin
                    chk($sformatf("v_at_yumi_ch%0d", c), 64'(resp_v[c]), 64'd1);
                    if (exp_q[c].size() == 0) begin
                        nchk++;
                        nerr++;
                        $display("FAIL pop_ch%0d: got a dequeue, expected none outstanding", c);
                    end else begin
                        mon_e = exp_q[c].pop_front();
                        chk($sformatf("head_ch%0d", c),
                            {27'd0, resp_rd[c*5 +: 5], resp_data[c*32 +: 32]},
                            {27'd0, mon_e.reg_id, mon_e.data});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [4:0] rd, input logic [31:0] d);
        load_resp_s e;
        returned_v       = 1'b1;
        returned_chan_id = 2'(ch);
        returned_reg_id  = rd;
        returned_data    = d;
        if (ch < NCH) begin
            e.reg_id = rd;
            e.data   = d;
            exp_q[ch].push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        returned_v = 1'b0;
        while (resp_v != 3'b000 && n < 20) begin
            resp_yumi = resp_v;
            tick();
            n++;
        end
        resp_yumi = 3'b000;
        chk("drain_empty", 64'(resp_v), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; returned_v = 1'b0; returned_data = '0; returned_reg_id = '0;
        returned_chan_id = '0; fifo_full = 1'b0; resp_yumi = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_v", 64'(resp_v), 64'd0);
        chk("rst_force", 64'(resp_force), 64'd0);
        chk("rst_yumi", 64'(yumi_o), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        tick();
        rst_n = 1'b1;

        // single packet, latency 1
        send(1, 5'd7, 32'hDEADBEEF);
        @(negedge clk); chk("t1_yumi", 64'(yumi_o), 64'd1);
        tick(); returned_v = 1'b0;
        @(negedge clk);
        chk("t1_v", 64'(resp_v), 64'b010);
        chk("t1_rd", 64'(resp_rd[9:5]), 64'd7);
        chk("t1_data", 64'(resp_data[63:32]), 64'hDEADBEEF);
        tick(); resp_yumi = 3'b010;
        @(negedge clk);
        tick(); resp_yumi = 3'b000;
        @(negedge clk); chk("t1_v_after", 64'(resp_v), 64'd0);

        // full queue and head-of-line blocking
        tick();
        for (int i = 0; i < 3; i++) begin
            send(0, 5'(i + 1), 32'h100 + 32'(i));
            @(negedge clk); chk("t2_acc", 64'(yumi_o), 64'd1);
            tick();
        end
        send(0, 5'd4, 32'h103);
        @(negedge clk); chk("t2_block", 64'(yumi_o), 64'd0);
        tick();
        @(negedge clk); chk("t2_block2", 64'(yumi_o), 64'd0);
        tick(); resp_yumi = 3'b001;
        @(negedge clk); chk("t2_no_enq_on_deq", 64'(yumi_o), 64'd0);
        tick(); resp_yumi = 3'b000;
        @(negedge clk); chk("t2_accept_after", 64'(yumi_o), 64'd1);
        tick(); send(1, 5'd9, 32'h900);
        @(negedge clk);
        chk("t2_ch1", 64'(yumi_o), 64'd1);
        chk("t2_v", 64'(resp_v), 64'b001);
        tick(); drain();

        // aging: force four cycles after valid, restart on new head
        send(0, 5'd5, 32'hA5A5A5A5);
        tick();
        send(0, 5'd6, 32'h5A5A5A5A);
        @(negedge clk);
        chk("t3_v", 64'(resp_v[0]), 64'd1);
        chk("t3_age0", 64'(resp_force[0]), 64'd0);
        tick(); returned_v = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); chk($sformatf("t3_age%0d", k), 64'(resp_force[0]), 64'd0);
            tick();
        end
        @(negedge clk); chk("t3_force_rise", 64'(resp_force[0]), 64'd1);
        tick(); resp_yumi = 3'b001;
        @(negedge clk); chk("t3_force_deq_cycle", 64'(resp_force[0]), 64'd1);
        tick(); resp_yumi = 3'b000;
        @(negedge clk);
        chk("t3_new_head_v", 64'(resp_v[0]), 64'd1);
        chk("t3_new_head_force", 64'(resp_force[0]), 64'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            @(negedge clk); chk($sformatf("t3_reage%0d", k), 64'(resp_force[0]), 64'd0);
        end
        tick();
        @(negedge clk); chk("t3_force_again", 64'(resp_force[0]), 64'd1);
        tick(); drain();

        // fifo-full force, sticky after the pulse
        send(1, 5'd10, 32'hF000000A);
        tick(); send(1, 5'd11, 32'hF000000B);
        tick(); send(1, 5'd12, 32'hF000000C); fifo_full = 1'b1;
        @(negedge clk); chk("t4_not_full", 64'(resp_force), 64'd0);
        tick(); returned_v = 1'b0;
        @(negedge clk); chk("t4_fifo_full", 64'(resp_force), 64'b010);
        tick(); fifo_full = 1'b0;
        @(negedge clk); chk("t4_sticky", 64'(resp_force[1]), 64'd1);
        tick(); resp_yumi = 3'b010;
        @(negedge clk);
        tick(); resp_yumi = 3'b000;
        @(negedge clk); chk("t4_new_head", 64'(resp_force[1]), 64'd0);
        tick(); drain();

        // pointer wrap on a depth-3 queue
        send(2, 5'd0, 32'hC0000000);
        tick(); send(2, 5'd1, 32'hC0000001);
        tick();
        for (int k = 2; k < 10; k++) begin
            send(2, 5'(k), 32'hC0000000 + 32'(k));
            resp_yumi = 3'b100;
            @(negedge clk); chk($sformatf("t5_pair%0d", k), 64'(yumi_o), 64'd1);
            tick();
        end
        resp_yumi = 3'b000;
        drain();

        // illegal channel id
        send(3, 5'd1, 32'h00000BAD);
        @(negedge clk);
        chk("t6_not_taken", 64'(yumi_o), 64'd0);
        chk("t6_err_pre", 64'(err), 64'd0);
        tick(); returned_v = 1'b0;
        @(negedge clk); chk("t6_err", 64'(err), 64'd1);
        tick();
        @(negedge clk); chk("t6_err_sticky", 64'(err), 64'd1);

        // reset in the middle of a burst
        tick(); send(0, 5'd1, 32'h11111111);
        tick(); send(1, 5'd2, 32'h22222222);
        tick(); send(0, 5'd3, 32'h33333333);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_v", 64'(resp_v), 64'd0);
        chk("t7_rst_force", 64'(resp_force), 64'd0);
        chk("t7_rst_yumi", 64'(yumi_o), 64'd0);
        chk("t7_rst_err", 64'(err), 64'd0);
        for (int c = 0; c < NCH; c++) exp_q[c].delete();
        returned_v = 1'b0;
        tick(); tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("t7_post_v", 64'(resp_v), 64'd0);
        chk("t7_post_err", 64'(err), 64'd0);
        tick(); send(0, 5'd17, 32'h12345678);
        tick(); returned_v = 1'b0;
        @(negedge clk); chk("t7_relive", 64'(resp_v), 64'b001);
        tick(); drain();

        for (int c = 0; c < NCH; c++)
            chk($sformatf("leftover_ch%0d", c), 64'(exp_q[c].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
